// File: rtl/demux_8_1_reg_pkg.sv
// demux_8_1_reg_pkg: shared sizes and select decode for the registered 1-to-8 demux
package demux_8_1_reg_pkg;
  localparam int NCH = 8;
  localparam int SEL_W = 3;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] CH_DEFAULT_DATA = '0;
  function automatic logic [NCH-1:0] load_vec(input logic bcast, input logic [SEL_W-1:0] sel);
    return bcast ? {NCH{1'b1}} : NCH'(1) << sel;
  endfunction
endpackage

// File: rtl/demux_8_1_reg_if.sv
// demux_8_1_reg_if: source and per-channel consumer handshakes of the demux
interface demux_8_1_reg_if;
  import demux_8_1_reg_pkg::*;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_select;
  logic                   in_bcast;
  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [NCH*WIDTH-1:0]   out_data;
  modport master (
    output in_valid, in_data, in_select, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_select, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_8_1_reg_slot.sv
// demux_8_1_reg_slot: one-entry holding register for a single output channel
module demux_8_1_reg_slot
  import demux_8_1_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
);
  assign free = !valid || ready;
  // data is kept after drain; only a new load replaces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= CH_DEFAULT_DATA;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_8_1_reg.sv
// demux_8_1_reg: registered 1-to-8 word demux with broadcast, per-channel slots and stall counter
module demux_8_1_reg
  import demux_8_1_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_8_1_reg_if.slave    bus,
  input  logic              clr_stall,
  output logic [CNT_W-1:0]  stall_count
);
  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic           accept;
  assign bus.in_ready = bus.in_bcast ? &free : free[bus.in_select];
  assign accept = bus.in_valid && bus.in_ready;
  // broadcast only goes when every slot is free, so it never lands partially
  assign load = accept ? load_vec(bus.in_bcast, bus.in_select) : '0;
  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_8_1_reg_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (bus.in_data),
      .ready (bus.out_ready[k]),
      .valid (bus.out_valid[k]),
      .q     (bus.out_data[k*WIDTH +: WIDTH]),
      .free  (free[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (clr_stall) stall_count <= '0;
    else if (bus.in_valid && !bus.in_ready && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_demux_8_1_reg.sv
// tb_demux_8_1_reg: directed checks of routing, backpressure, broadcast, reset and stall counter
module tb_demux_8_1_reg;
  import demux_8_1_reg_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_stall = 1'b0;
  logic [15:0] stall_count;
  int          errors = 0;
  int          checks = 0;
  demux_8_1_reg_if bus ();
  demux_8_1_reg #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clr_stall   (clr_stall),
    .stall_count (stall_count)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ch(input int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction
  task automatic send(input logic [2:0] sel, input logic [31:0] d, input logic bc);
    bus.in_valid = 1'b1;
    bus.in_select = sel;
    bus.in_data = d;
    bus.in_bcast = bc;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_select = '0;
    bus.in_bcast = 1'b0;
    bus.out_ready = 8'h00;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    send(3'd2, 32'h2222_0000, 1'b0);
    #1 chk("rst_pre_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    send(3'd5, 32'h5555_0000, 1'b0);
    cyc();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h24);
    chk("pre_rst_ch5", ch(5), 32'h5555_0000);
    send(3'd2, 32'h2222_1111, 1'b0);
    cyc();
    chk("pre_rst_stall", 32'(stall_count), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ch2", ch(2), 32'h0);
    chk("rst_ch5", ch(5), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      send(3'(k), 32'hA000_0000 + 32'(k), 1'b0);
      #1 chk($sformatf("uni_ready%0d", k), 32'(bus.in_ready), 32'h1);
      cyc();
      chk($sformatf("uni_valid%0d", k), 32'(bus.out_valid), 32'h1 << k);
      chk($sformatf("uni_data%0d", k), ch(k), 32'hA000_0000 + 32'(k));
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("uni_drained", 32'(bus.out_valid), 32'h0);
    chk("uni_retain7", ch(7), 32'hA000_0007);
    bus.out_ready = 8'hF7;
    send(3'd3, 32'h11, 1'b0);
    cyc();
    chk("bp_hold_valid", 32'(bus.out_valid), 32'h08);
    chk("bp_hold_data", ch(3), 32'h11);
    send(3'd3, 32'h22, 1'b0);
    #1 chk("bp_not_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("bp_stall1", 32'(stall_count), 32'h1);
    chk("bp_held", ch(3), 32'h11);
    send(3'd4, 32'h44, 1'b0);
    #1 chk("bp_ch4_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("bp_ch4_valid", 32'(bus.out_valid), 32'h18);
    chk("bp_ch4_data", ch(4), 32'h44);
    send(3'd3, 32'h22, 1'b0);
    cyc();
    chk("bp_stall2", 32'(stall_count), 32'h2);
    chk("bp_valid_ch3_only", 32'(bus.out_valid), 32'h08);
    bus.out_ready = 8'hFF;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("bp_swap_valid", 32'(bus.out_valid), 32'h08);
    chk("bp_swap_data", ch(3), 32'h22);
    bus.in_valid = 1'b0;
    cyc();
    chk("bp_empty", 32'(bus.out_valid), 32'h0);
    chk("bp_stall_kept", 32'(stall_count), 32'h2);
    bus.out_ready = 8'hBF;
    send(3'd6, 32'h66, 1'b0);
    cyc();
    send(3'd0, 32'hDEAD_BEEF, 1'b1);
    #1 chk("bc_blocked", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("bc_no_partial", 32'(bus.out_valid), 32'h40);
    chk("bc_ch0_old", ch(0), 32'hA000_0000);
    chk("bc_ch6_old", ch(6), 32'h66);
    chk("bc_stall3", 32'(stall_count), 32'h3);
    bus.out_ready = 8'hFF;
    #1 chk("bc_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("bc_all_valid", 32'(bus.out_valid), 32'hFF);
    for (int k = 0; k < 8; k++) chk($sformatf("bc_data%0d", k), ch(k), 32'hDEAD_BEEF);
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    cyc();
    chk("bc_drained", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 8'hFE;
    send(3'd0, 32'h0C0C_0C0C, 1'b0);
    clr_stall = 1'b1;
    cyc();
    clr_stall = 1'b0;
    chk("cnt_cleared", 32'(stall_count), 32'h0);
    repeat (70000) cyc();
    chk("cnt_saturated", 32'(stall_count), 32'hFFFF);
    chk("cnt_ch0_held", ch(0), 32'h0C0C_0C0C);
    clr_stall = 1'b1;
    cyc();
    clr_stall = 1'b0;
    chk("cnt_clear_wins", 32'(stall_count), 32'h0);
    cyc();
    chk("cnt_restart", 32'(stall_count), 32'h1);
    bus.in_valid = 1'b0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
